// File: rtl/i2c_pkg.sv
// Shared I2C definitions: field widths, ACK/NACK bus levels and the one-hot
// target state encoding.
package i2c_pkg;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned BYTE_W = 8;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    typedef enum logic [7:0] {
        IDLE      = 8'b0000_0001,
        ADDR      = 8'b0000_0010,
        ADDR_ACK  = 8'b0000_0100,
        WRITE     = 8'b0000_1000,
        WR_ACK    = 8'b0001_0000,
        READ      = 8'b0010_0000,
        RD_ACK    = 8'b0100_0000,
        WAIT_STOP = 8'b1000_0000
    } state_t;

endpackage

// File: rtl/i2c_target_mb_if.sv
// Shared SCL/SDA bus bundle: the controller drives SCL/SDA_OUT, the target
// pulls SDA_IN low; bus SDA is SDA_OUT & SDA_IN.
interface i2c_target_mb_if;

    logic SCL;
    logic SDA_OUT;
    logic SDA_OE;
    logic SDA_IN;

    modport master (output SCL, output SDA_OUT, output SDA_OE, input SDA_IN);
    modport slave  (input SCL, input SDA_OUT, input SDA_OE, output SDA_IN);

endinterface

// File: rtl/i2c_bus_cond.sv
// I2C bus conditioner: synchronises SCL/SDA and reports SCL edges plus
// START/STOP conditions as single-cycle pulses.
module i2c_bus_cond #(
    parameter int unsigned SYNC_DEPTH = 2
) (
    input  logic CLK,
    input  logic RESET,
    input  logic SCL,
    input  logic SDA,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_DEPTH-1:0] scl_sync;
    logic [SYNC_DEPTH-1:0] sda_sync;
    logic                  scl_d;
    logic                  sda_d;
    logic                  scl_s;
    logic                  scl_hold;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_DEPTH-2:0], SCL};
            sda_sync <= {sda_sync[SYNC_DEPTH-2:0], SDA};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s    = scl_sync[SYNC_DEPTH-1];
    assign sda_s    = sda_sync[SYNC_DEPTH-1];
    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;

    // SCL must be high on both sides of the SDA edge; a simultaneous SCL edge
    // makes it an ordinary data bit rather than START/STOP.
    assign scl_hold  = scl_s & scl_d;
    assign start_det = scl_hold & sda_d & ~sda_s;
    assign stop_det  = scl_hold & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_target_mb.sv
// Multi-byte I2C target with read/write payloads of NBYTES bytes.
// Optional I2C_GENERAL_CALL_EN: also accept writes to general-call address 0x00.
module i2c_target_mb
    import i2c_pkg::*;
#(
    parameter int unsigned NBYTES   = 2,
    parameter int unsigned SCL_FILT = 2
) (
    input  logic                     CLK,
    input  logic                     RESET,
    i2c_target_mb_if.slave           bus,
    input  logic [ADDR_W-1:0]        I2C_ADDR,
    input  logic [BYTE_W*NBYTES-1:0] RD_DATA,
    output logic [BYTE_W*NBYTES-1:0] WR_DATA,
    output logic                     WR_VALID,
    output logic                     RD_START,
    output logic                     BUSY
);

    localparam int unsigned PW  = BYTE_W * NBYTES;
    localparam int unsigned BCW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);

    state_t            state, state_nxt;
    logic [3:0]        bit_cnt;
    logic [BCW-1:0]    byte_cnt, byte_nxt;
    logic [BYTE_W-1:0] shreg;
    logic [PW-1:0]     pbuf;
    logic              rw;
    logic              sda_q;

    logic              sda_s, scl_rise, scl_fall, start_det, stop_det;
    logic              addr_hit, byte_end, ack_end;
    int unsigned       cur_sh, nxt_sh;
    logic [BYTE_W-1:0] cur_byte, nxt_byte;
    logic              unused_oe;

    assign unused_oe  = bus.SDA_OE;
    assign bus.SDA_IN = sda_q;

    i2c_bus_cond #(.SYNC_DEPTH(SCL_FILT)) u_cond (
        .CLK       (CLK),
        .RESET     (RESET),
        .SCL       (bus.SCL),
        .SDA       (bus.SDA_OUT & bus.SDA_IN),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    always_comb begin
        addr_hit = (shreg[7:1] == I2C_ADDR);
`ifdef I2C_GENERAL_CALL_EN
        if ((shreg[7:1] == '0) && !shreg[0])
            addr_hit = 1'b1;
`endif
        // bit_cnt counts SCL rises and wraps 8->0 on the ACK rise, so a fall
        // at 8 ends the data bits and a fall at 0 ends the ACK slot.
        byte_end = scl_fall && (bit_cnt == 4'd8);
        ack_end  = scl_fall && (bit_cnt == 4'd0);
        byte_nxt = (byte_cnt == LAST_BYTE) ? '0 : byte_cnt + 1'b1;
        cur_sh   = BYTE_W * (NBYTES - 1 - 32'(byte_cnt));
        nxt_sh   = BYTE_W * (NBYTES - 1 - 32'(byte_nxt));
        cur_byte = BYTE_W'(pbuf >> cur_sh);
        nxt_byte = BYTE_W'(pbuf >> nxt_sh);

        state_nxt = state;
        if (stop_det)
            state_nxt = IDLE;
        else if (start_det)
            state_nxt = ADDR;
        else begin
            case (state)
                ADDR:     if (byte_end) state_nxt = addr_hit ? ADDR_ACK : WAIT_STOP;
                ADDR_ACK: if (ack_end)  state_nxt = rw ? READ : WRITE;
                WRITE:    if (byte_end) state_nxt = WR_ACK;
                WR_ACK:   if (ack_end)  state_nxt = WRITE;
                READ:     if (byte_end) state_nxt = RD_ACK;
                RD_ACK: begin
                    if (scl_rise && (sda_s == NACK))
                        state_nxt = WAIT_STOP;
                    else if (ack_end)
                        state_nxt = READ;
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            bit_cnt  <= '0;
            byte_cnt <= '0;
            shreg    <= '0;
            pbuf     <= '0;
            rw       <= 1'b0;
            sda_q    <= 1'b1;
            WR_DATA  <= '0;
            WR_VALID <= 1'b0;
            RD_START <= 1'b0;
            BUSY     <= 1'b0;
        end else begin
            WR_VALID <= 1'b0;
            RD_START <= 1'b0;
            if (stop_det) begin
                bit_cnt  <= '0;
                byte_cnt <= '0;
                sda_q    <= 1'b1;
                BUSY     <= 1'b0;
            end else if (start_det) begin
                bit_cnt  <= '0;
                byte_cnt <= '0;
                sda_q    <= 1'b1;
            end else begin
                if (scl_rise) begin
                    bit_cnt <= (bit_cnt == 4'd8) ? '0 : bit_cnt + 4'd1;
                    shreg   <= {shreg[BYTE_W-2:0], sda_s};
                end
                case (state)
                    ADDR: if (byte_end) begin
                        rw <= shreg[0];
                        if (addr_hit) begin
                            sda_q <= ACK;
                            BUSY  <= 1'b1;
                        end
                    end
                    ADDR_ACK: if (ack_end) begin
                        if (rw) begin
                            pbuf     <= RD_DATA;
                            RD_START <= 1'b1;
                            sda_q    <= RD_DATA[PW-1];
                        end else begin
                            sda_q <= 1'b1;
                        end
                    end
                    WRITE: if (byte_end) begin
                        pbuf  <= (pbuf & ~(PW'(8'hFF) << cur_sh)) | (PW'(shreg) << cur_sh);
                        sda_q <= ACK;
                    end
                    WR_ACK: if (ack_end) begin
                        sda_q    <= 1'b1;
                        byte_cnt <= byte_nxt;
                        if (byte_cnt == LAST_BYTE) begin
                            WR_DATA  <= pbuf;
                            WR_VALID <= 1'b1;
                        end
                    end
                    READ: if (scl_fall) begin
                        if (bit_cnt == 4'd8)
                            sda_q <= 1'b1;
                        else if (bit_cnt != 4'd0)
                            sda_q <= cur_byte[3'(4'd7 - bit_cnt)];
                    end
                    RD_ACK: if (ack_end) begin
                        byte_cnt <= byte_nxt;
                        sda_q    <= nxt_byte[BYTE_W-1];
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_mb.sv
// Directed bench for i2c_target_mb: bit-banged controller with a queue of
// expected results compared when the DUT responds.
module tb_i2c_target_mb;
    import i2c_pkg::*;

    localparam int unsigned NB = 2;
    localparam int Q = 6;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [6:0]  I2C_ADDR = 7'h2A;
    logic [15:0] RD_DATA = 16'h1234;
    logic [15:0] WR_DATA;
    logic        WR_VALID, RD_START, BUSY;

    i2c_target_mb_if bus_if();

    i2c_target_mb #(.NBYTES(NB), .SCL_FILT(2)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .bus      (bus_if),
        .I2C_ADDR (I2C_ADDR),
        .RD_DATA  (RD_DATA),
        .WR_DATA  (WR_DATA),
        .WR_VALID (WR_VALID),
        .RD_START (RD_START),
        .BUSY     (BUSY)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;
    int wv_cnt = 0;
    int rs_cnt = 0;
    int sda_low_cnt = 0;
    logic [31:0] exp_q[$];
    logic [15:0] exp_wr = 16'h0000;

    always @(negedge CLK) begin
        if (WR_VALID === 1'b1) wv_cnt++;
        if (RD_START === 1'b1) rs_cnt++;
        if (bus_if.SDA_IN === 1'b0) sda_low_cnt++;
    end

    initial begin
        #10ms;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic wt(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic expect_val(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL %s observed=%h expected=<none>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    task automatic clock_bit(input logic b, output logic s);
        bus_if.SDA_OUT = b;
        wt(Q);
        bus_if.SCL = 1'b1;
        wt(Q);
        s = bus_if.SDA_OUT & bus_if.SDA_IN;
        wt(Q);
        bus_if.SCL = 1'b0;
        wt(Q);
    endtask

    task automatic bus_start();
        bus_if.SDA_OUT = 1'b1;
        wt(Q);
        bus_if.SCL = 1'b1;
        wt(Q);
        bus_if.SDA_OUT = 1'b0;
        wt(Q);
        bus_if.SCL = 1'b0;
        wt(Q);
    endtask

    task automatic bus_stop();
        bus_if.SDA_OUT = 1'b0;
        wt(Q);
        bus_if.SCL = 1'b1;
        wt(Q);
        bus_if.SDA_OUT = 1'b1;
        wt(2 * Q);
    endtask

    task automatic write_byte(input string tag, input logic [7:0] d, input logic exp_ack);
        logic [7:0] sh;
        logic s;
        sh = d;
        for (int i = 0; i < 8; i++) begin
            clock_bit(sh[7], s);
            sh = sh << 1;
        end
        expect_val(32'(exp_ack));
        clock_bit(1'b1, s);
        check(tag, 32'(s));
    endtask

    task automatic read_byte(input string tag, input logic [7:0] exp_d, input logic ack);
        logic [7:0] r;
        logic s;
        r = '0;
        expect_val(32'(exp_d));
        for (int i = 0; i < 8; i++) begin
            clock_bit(1'b1, s);
            r = {r[6:0], s};
        end
        check(tag, 32'(r));
        clock_bit(ack, s);
    endtask

    initial begin
        int wv0, rs0, low0;
        logic gc_ack;
        bus_if.SCL = 1'b1;
        bus_if.SDA_OUT = 1'b1;
        bus_if.SDA_OE = 1'b1;
        wt(5);
        RESET = 1'b0;
        wt(2);

        // reset state
        expect_val(32'(1'b1)); check("rst_sda_in", 32'(bus_if.SDA_IN));
        expect_val(32'h0);     check("rst_wr_data", 32'(WR_DATA));
        expect_val(32'h0);     check("rst_wr_valid", 32'(WR_VALID));
        expect_val(32'h0);     check("rst_rd_start", 32'(RD_START));
        expect_val(32'h0);     check("rst_busy", 32'(BUSY));

        // 1: write 0xBEEF
        wv0 = wv_cnt;
        bus_start();
        write_byte("t1_addr_ack", 8'h54, ACK);
        expect_val(32'h1); check("t1_busy", 32'(BUSY));
        write_byte("t1_b0_ack", 8'hBE, ACK);
        write_byte("t1_b1_ack", 8'hEF, ACK);
        bus_stop();
        exp_wr = 16'hBEEF;
        expect_val(32'(exp_wr)); check("t1_wr_data", 32'(WR_DATA));
        expect_val(32'd1);       check("t1_wr_valid_pulses", 32'(wv_cnt - wv0));
        expect_val(32'h0);       check("t1_busy_after_stop", 32'(BUSY));

        // 2: read with wrap; RD_DATA changes after capture must not be seen
        rs0 = rs_cnt;
        bus_start();
        write_byte("t2_addr_ack", 8'h55, ACK);
        RD_DATA = 16'hDEAD;
        read_byte("t2_rd0", 8'h12, ACK);
        read_byte("t2_rd1", 8'h34, ACK);
        read_byte("t2_rd_wrap", 8'h12, NACK);
        expect_val(32'd1); check("t2_rd_start_pulses", 32'(rs_cnt - rs0));
        expect_val(32'h1); check("t2_busy_wait_stop", 32'(BUSY));
        bus_stop();
        RD_DATA = 16'h1234;
        expect_val(32'h0); check("t2_busy_after_stop", 32'(BUSY));

        // 3: address mismatch
        wv0 = wv_cnt;
        low0 = sda_low_cnt;
        bus_start();
        write_byte("t3_addr_nack", 8'h56, NACK);
        write_byte("t3_data_nack", 8'hAA, NACK);
        expect_val(32'h0); check("t3_busy", 32'(BUSY));
        bus_stop();
        expect_val(32'd0); check("t3_sda_low_cycles", 32'(sda_low_cnt - low0));
        expect_val(32'd0); check("t3_wr_valid_pulses", 32'(wv_cnt - wv0));

        // 4: partial write, repeated START, read
        wv0 = wv_cnt;
        rs0 = rs_cnt;
        bus_start();
        write_byte("t4_addr_ack", 8'h54, ACK);
        write_byte("t4_b0_ack", 8'hAB, ACK);
        bus_start();
        write_byte("t4_raddr_ack", 8'h55, ACK);
        read_byte("t4_rd0", 8'h12, NACK);
        bus_stop();
        expect_val(32'(exp_wr)); check("t4_wr_data", 32'(WR_DATA));
        expect_val(32'd0);       check("t4_wr_valid_pulses", 32'(wv_cnt - wv0));
        expect_val(32'd1);       check("t4_rd_start_pulses", 32'(rs_cnt - rs0));

        // 5: reset after bit 4 of the first data byte
        bus_start();
        write_byte("t5_addr_ack", 8'h54, ACK);
        begin
            logic s;
            clock_bit(1'b1, s);
            clock_bit(1'b1, s);
            clock_bit(1'b0, s);
            clock_bit(1'b0, s);
        end
        RESET = 1'b1;
        wt(1);
        exp_wr = 16'h0000;
        expect_val(32'(1'b1));   check("t5_sda_in_reset", 32'(bus_if.SDA_IN));
        expect_val(32'h0);       check("t5_busy_reset", 32'(BUSY));
        expect_val(32'(exp_wr)); check("t5_wr_data_reset", 32'(WR_DATA));
        RESET = 1'b0;
        wt(Q);
        wv0 = wv_cnt;
        bus_start();
        write_byte("t5_addr_ack2", 8'h54, ACK);
        write_byte("t5_b0_ack", 8'h5A, ACK);
        write_byte("t5_b1_ack", 8'hA5, ACK);
        bus_stop();
        exp_wr = 16'h5AA5;
        expect_val(32'(exp_wr)); check("t5_wr_data", 32'(WR_DATA));
        expect_val(32'd1);       check("t5_wr_valid_pulses", 32'(wv_cnt - wv0));

        // 6: general call
`ifdef I2C_GENERAL_CALL_EN
        gc_ack = ACK;
`else
        gc_ack = NACK;
`endif
        wv0 = wv_cnt;
        bus_start();
        write_byte("t6_gc_addr", 8'h00, gc_ack);
        write_byte("t6_b0", 8'h01, gc_ack);
        write_byte("t6_b1", 8'h02, gc_ack);
        bus_stop();
        if (gc_ack == ACK) exp_wr = 16'h0102;
        expect_val(32'(exp_wr));                  check("t6_wr_data", 32'(WR_DATA));
        expect_val((gc_ack == ACK) ? 32'd1 : 32'd0); check("t6_wr_valid_pulses", 32'(wv_cnt - wv0));

        // 7: two back-to-back payloads, then a short write that is discarded
        wv0 = wv_cnt;
        bus_start();
        write_byte("t7_addr_ack", 8'h54, ACK);
        write_byte("t7_b0", 8'h11, ACK);
        write_byte("t7_b1", 8'h22, ACK);
        write_byte("t7_b2", 8'h33, ACK);
        write_byte("t7_b3", 8'h44, ACK);
        bus_stop();
        exp_wr = 16'h3344;
        expect_val(32'(exp_wr)); check("t7_wr_data", 32'(WR_DATA));
        expect_val(32'd2);       check("t7_wr_valid_pulses", 32'(wv_cnt - wv0));
        wv0 = wv_cnt;
        bus_start();
        write_byte("t7_addr_ack2", 8'h54, ACK);
        write_byte("t7_short", 8'h77, ACK);
        bus_stop();
        expect_val(32'(exp_wr)); check("t7_wr_data_short", 32'(WR_DATA));
        expect_val(32'd0);       check("t7_wr_valid_short", 32'(wv_cnt - wv0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
